// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Round-robin arbiter sharing one UART transmitter between N byte
// producers. One byte is handed over per transfer; each source gets an
// acceptance pulse (ack) when its byte is latched and a completion pulse
// (sent) when the transmitter reports done. A watchdog aborts a transfer
// whose tx_done never arrives and reports it on err.
//
// Handshake semantics (all outputs registered, no input-to-output paths):
//   - req[i] is a level. While the arbiter is IDLE and the transmitter is not
//     busy, the sampled req vector is arbitrated and the winner's byte is
//     latched on that edge; ack[i] and tx_start are high for exactly the
//     following cycle. A source that still holds req in the first IDLE cycle
//     after its ack is offering a new byte.
//   - tx_start is a one-cycle pulse; tx_data holds the latched byte from the
//     tx_start cycle until the next grant.
//   - tx_done is a one-cycle pulse, honoured only while WAITing; it produces
//     sent[cur_src] in the next cycle. tx_done in IDLE is ignored.
//   - At most one of ack/sent/err is high in any cycle.

module uart_tx_arbiter #(
  parameter int N       = 4,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 4096
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N-1:0]                  req,
  input  logic [N*DATA_W-1:0]           req_data,
  output logic [N-1:0]                  ack,
  output logic [N-1:0]                  sent,
  output logic                          err,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] cur_src,
  output logic                          tx_start,
  output logic [DATA_W-1:0]             tx_data,
  input  logic                          tx_busy,
  input  logic                          tx_done,
  output logic                          state_dbg
);

  // Source index width and watchdog counter width.
  localparam int SW = (N > 1) ? $clog2(N) : 1;
  localparam int WW = $clog2(TIMEOUT);

  // Last watchdog value before the transfer is declared stalled.
  localparam logic [WW-1:0] WDOG_LAST = WW'(TIMEOUT - 1);

  // Reset value of the round-robin pointer: N-1 so source 0 wins first.
  localparam logic [SW-1:0] LAST_INIT = SW'(N - 1);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t          state;
  logic [SW-1:0]   last;
  logic [WW-1:0]   wdog;

  // Arbitration result for the current req vector.
  logic            win_vld;
  logic [SW-1:0]   win_idx;
  logic [DATA_W-1:0] win_byte;

  // Search scratch.
  int unsigned     cand;
  logic [SW-1:0]   cidx;

  // Debug view of the FSM: 0 = IDLE, 1 = WAIT.
  assign state_dbg = (state == WAIT);

  // Round-robin search: first set req bit starting at (last+1) mod N, with wrap.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = 0;
    cidx    = '0;
    for (int k = 1; k <= N; k++) begin
      cand = 32'(last) + 32'(k);
      if (cand >= 32'(N)) begin
        cand = cand - 32'(N);
      end
      cidx = cand[SW-1:0];
      if (!win_vld && req[cidx]) begin
        win_vld = 1'b1;
        win_idx = cidx;
      end
    end
  end

  // Byte offered by the arbitration winner.
  always_comb begin
    win_byte = req_data[win_idx*DATA_W +: DATA_W];
  end

  // Grant/wait FSM with registered pulses, byte latch and watchdog.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      last     <= LAST_INIT;
      wdog     <= '0;
      ack      <= '0;
      sent     <= '0;
      err      <= 1'b0;
      tx_start <= 1'b0;
      tx_data  <= '0;
      cur_src  <= '0;
    end else begin
      // Pulses default low; each is raised for a single cycle below.
      ack      <= '0;
      sent     <= '0;
      err      <= 1'b0;
      tx_start <= 1'b0;

      case (state)
        IDLE: begin
          // tx_done is deliberately not looked at here.
          if (win_vld && !tx_busy) begin
            state        <= WAIT;
            tx_data      <= win_byte;
            cur_src      <= win_idx;
            ack[win_idx] <= 1'b1;
            tx_start     <= 1'b1;
            wdog         <= '0;
          end
        end

        WAIT: begin
          // All req bits are ignored while a byte is in flight.
          // A completion arriving on the last watchdog cycle still counts
          // as a successful transfer, so tx_done is checked first.
          if (tx_done) begin
            sent[cur_src] <= 1'b1;
            last          <= cur_src;
            state         <= IDLE;
          end else if (wdog == WDOG_LAST) begin
            err   <= 1'b1;
            last  <= cur_src;
            state <= IDLE;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter (N=4, DATA_W=8, TIMEOUT=16).
// Inputs change and outputs are sampled on the falling clock edge.

module tb_uart_tx_arbiter;

  localparam int N       = 4;
  localparam int DATA_W  = 8;
  localparam int TIMEOUT = 16;

  // Clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // DUT signals
  logic [N-1:0]        req = '0;
  logic [N*DATA_W-1:0] req_data = '0;
  logic [N-1:0]        ack;
  logic [N-1:0]        sent;
  logic                err;
  logic [1:0]          cur_src;
  logic                tx_start;
  logic [DATA_W-1:0]   tx_data;
  logic                tx_busy = 1'b0;
  logic                tx_done = 1'b0;
  logic                state_dbg;

  uart_tx_arbiter #(
    .N       (N),
    .DATA_W  (DATA_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_data  (req_data),
    .ack       (ack),
    .sent      (sent),
    .err       (err),
    .cur_src   (cur_src),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .tx_busy   (tx_busy),
    .tx_done   (tx_done),
    .state_dbg (state_dbg)
  );

  // Scoreboard
  int n_checks = 0;
  int n_fail   = 0;
  logic [3:0] exp_q[$];

  typedef struct {
    logic [N-1:0]        req;
    logic [N*DATA_W-1:0] data;
    int                  done_after;
    bit                  hold;
    int                  exp_src;
    logic [DATA_W-1:0]   exp_byte;
  } vec_t;

  vec_t tbl[9];

  function automatic logic [3:0] onehot(input logic [3:0] i);
    onehot = 4'b0001 << i;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Wait (bounded) for tx_start and check the grant against the expected source.
  task automatic grant(input int exp_src, input logic [DATA_W-1:0] exp_byte, output int waited);
    logic [3:0] e;
    bit got;
    got = 1'b0;
    waited = 0;
    exp_q.push_back(4'(exp_src));
    while (!got && waited < 40) begin
      step();
      waited++;
      if (tx_start) got = 1'b1;
    end
    e = exp_q.pop_front();
    check("grant_seen", 32'(got), 32'd1);
    if (got) begin
      check("grant_cur_src", 32'(cur_src), 32'(e));
      check("grant_ack", 32'(ack), 32'(onehot(e)));
      check("grant_tx_data", 32'(tx_data), 32'(exp_byte));
      check("grant_state", 32'(state_dbg), 32'd1);
      check("grant_no_sent", 32'(sent), 32'd0);
      check("grant_no_err", 32'(err), 32'd0);
    end
  endtask

  // Hold the transfer for done_after cycles, then pulse tx_done and check sent.
  task automatic finish_xfer(input int done_after, input int src, input logic [DATA_W-1:0] bv);
    for (int i = 1; i < done_after; i++) begin
      step();
      check("wait_tx_start", 32'(tx_start), 32'd0);
      check("wait_ack", 32'(ack), 32'd0);
      check("wait_sent", 32'(sent), 32'd0);
      check("wait_err", 32'(err), 32'd0);
      check("wait_cur_src", 32'(cur_src), 32'(src));
      check("wait_tx_data", 32'(tx_data), 32'(bv));
    end
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    check("sent_pulse", 32'(sent), 32'(onehot(4'(src))));
    check("sent_no_err", 32'(err), 32'd0);
    check("sent_idle_gap", 32'(tx_start), 32'd0);
    check("sent_state_idle", 32'(state_dbg), 32'd0);
  endtask

  // At most one of ack/sent/err per cycle, and tx_start coincides with ack.
  always @(negedge clk) begin
    check("one_pulse", 32'($countones({ack, sent, err}) <= 1), 32'd1);
    check("start_with_ack", 32'(tx_start), 32'(ack != '0));
  end

  // Global time limit
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "time limit");
  end

  initial begin
    int w;

    //            req      data          done hold src byte
    tbl[0] = '{4'b1111, 32'h44332211,   5, 1'b1, 0, 8'h11};
    tbl[1] = '{4'b1111, 32'h48372615,   5, 1'b1, 1, 8'h26};
    tbl[2] = '{4'b1111, 32'h4C3B2A19,   5, 1'b1, 2, 8'h3B};
    tbl[3] = '{4'b1111, 32'h503F2E1D,   5, 1'b1, 3, 8'h50};
    tbl[4] = '{4'b1111, 32'h54433221,   5, 1'b0, 0, 8'h21};
    tbl[5] = '{4'b0100, 32'h00A50000,  10, 1'b0, 2, 8'hA5};
    tbl[6] = '{4'b1001, 32'hC300007E,   7, 1'b0, 3, 8'hC3};
    tbl[7] = '{4'b0011, 32'h0000F00F,  16, 1'b0, 0, 8'h0F};
    tbl[8] = '{4'b1010, 32'h99006600,   3, 1'b0, 1, 8'h66};

    // Reset
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_sent", 32'(sent), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_tx_start", 32'(tx_start), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_cur_src", 32'(cur_src), 32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);
    step();

    // Table: rotation with all requests held, then mixed request patterns
    // (including tx_done on the final watchdog cycle in tbl[7]).
    for (int v = 0; v < 9; v++) begin
      req      = tbl[v].req;
      req_data = tbl[v].data;
      grant(tbl[v].exp_src, tbl[v].exp_byte, w);
      if (!tbl[v].hold) begin
        req      = '0;
        req_data = ~tbl[v].data;
      end
      finish_xfer(tbl[v].done_after, tbl[v].exp_src, tbl[v].exp_byte);
    end
    req = '0;
    step();

    // Busy gating: req[1] held for 20 cycles while the transmitter is busy.
    tx_busy  = 1'b1;
    req      = 4'b0010;
    req_data = 32'h00008100;
    for (int i = 0; i < 20; i++) begin
      step();
      check("busy_no_start", 32'(tx_start), 32'd0);
      check("busy_no_ack", 32'(ack), 32'd0);
      check("busy_state", 32'(state_dbg), 32'd0);
    end
    tx_busy = 1'b0;
    grant(1, 8'h81, w);
    check("busy_grant_latency", 32'(w), 32'd1);
    req = '0;
    finish_xfer(4, 1, 8'h81);

    // tx_done pulsed in IDLE has no effect.
    step();
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check("idle_done_sent", 32'(sent), 32'd0);
      check("idle_done_err", 32'(err), 32'd0);
      check("idle_done_start", 32'(tx_start), 32'd0);
      check("idle_done_state", 32'(state_dbg), 32'd0);
      step();
    end

    // Watchdog: sources 1 and 2 pending, last = 1, so 2 wins and stalls.
    req      = 4'b0110;
    req_data = 32'h005A3C00;
    grant(2, 8'h5A, w);
    for (int i = 1; i < TIMEOUT; i++) begin
      step();
      check("wdog_no_err", 32'(err), 32'd0);
      check("wdog_no_sent", 32'(sent), 32'd0);
      check("wdog_cur_src", 32'(cur_src), 32'd2);
    end
    step();
    check("wdog_err", 32'(err), 32'd1);
    check("wdog_err_no_sent", 32'(sent), 32'd0);
    check("wdog_state_idle", 32'(state_dbg), 32'd0);
    // last moved to 2, so pending source 1 wins next.
    grant(1, 8'h3C, w);
    check("wdog_next_latency", 32'(w), 32'd1);
    req = '0;
    finish_xfer(3, 1, 8'h3C);

    // Reset mid-WAIT with all sources requesting.
    req      = 4'b1111;
    req_data = 32'hDDCCBBAA;
    grant(2, 8'hCC, w);
    repeat (3) step();
    rst_n = 1'b0;
    step();
    check("midrst_ack", 32'(ack), 32'd0);
    check("midrst_sent", 32'(sent), 32'd0);
    check("midrst_err", 32'(err), 32'd0);
    check("midrst_tx_start", 32'(tx_start), 32'd0);
    check("midrst_tx_data", 32'(tx_data), 32'd0);
    check("midrst_cur_src", 32'(cur_src), 32'd0);
    check("midrst_state", 32'(state_dbg), 32'd0);
    rst_n = 1'b1;
    grant(0, 8'hAA, w);
    check("midrst_grant_latency", 32'(w), 32'd1);
    req = '0;
    finish_xfer(4, 0, 8'hAA);
    repeat (3) begin
      step();
      check("tail_quiet", 32'({ack, sent, err, tx_start}), 32'd0);
    end

    check("exp_q_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares one UART transmitter between N byte-producing requesters. It sits between the requesters and the transmitter's start/data/done interface. It hands the transmitter one byte at a time and reports per-source acceptance and completion, with a watchdog on a stalled transmitter. This is the companion controller for the receive path's baud-tick-driven UART datapath.

## Interface
- N, 4: number of requesters (2..16).
- DATA_W, 8: byte width.
- TIMEOUT, 4096: maximum cycles to wait for tx_done after tx_start (≥ 16).

- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- req  input  N  per-source send request, level.
- req_data  input  N*DATA_W  flat bus; source i byte at [i*DATA_W +: DATA_W].
- ack  output  N  one-cycle pulse: byte of source i latched.
- sent  output  N  one-cycle pulse: byte of source i fully transmitted.
- err  output  1  one-cycle pulse: watchdog expired.
- cur_src  output  clog2(N)  index of the source currently owning the transmitter.
- tx_start  output  1  one-cycle start pulse to transmitter.
- tx_data  output  DATA_W  byte to transmitter, stable from tx_start until the return to IDLE.
- tx_busy  input  1  transmitter busy level.
- tx_done  input  1  transmitter one-cycle completion pulse.

## Operation
- FSM states: IDLE and WAIT.
- IDLE → WAIT when (req != 0) and !tx_busy.
  - Winner = first set req bit searching from (last+1) mod N upward with wrap.
  - On that edge: tx_data ← winner's byte, cur_src ← winner, ack[winner] ← 1, tx_start ← 1, wdog ← 0.
- WAIT:
  - tx_start and ack are 0 after their single cycle.
  - wdog increments each cycle.
  - On tx_done: sent[cur_src] pulses, last ← cur_src, go to IDLE.
  - If wdog reaches TIMEOUT-1 with no tx_done: err pulses, last ← cur_src, go to IDLE. sent is not pulsed.
- Simultaneous tx_done and timeout in the same cycle: tx_done wins. sent pulses and err does not.
- req bits of the owning source are ignored in WAIT, and so are all other req bits.
- A requester must deassert req (or present a new byte) by the first IDLE cycle after its ack. A request still held is treated as a new byte.
- Only one ack, sent or err bit is ever high in a given cycle.
- tx_done seen in IDLE is ignored.
- Reset values: state IDLE, last = N-1 (source 0 wins first), ack = 0, sent = 0, err = 0, tx_start = 0, tx_data = 0, cur_src = 0, wdog = 0.
- Reset mid-transfer: everything returns to reset values on the next edge. The in-flight byte gets no sent or err.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- Grant latency: req sampled high in IDLE at edge k gives ack and tx_start high during cycle k+1.
- Completion: tx_done high at edge m (in WAIT) gives sent high during cycle m+1 and state IDLE in cycle m+1.
- The earliest next grant is sampled at edge m+1, so there is a minimum one idle cycle between transfers.
- Timeout: err is high exactly TIMEOUT cycles after the tx_start cycle.
- Back-to-back fairness: with all N requests held, grants rotate 0, 1, …, N-1, 0 (one per transfer).

## Test plan
- Single source: req[2]=1, data 0xA5, tx_done returned 10 cycles after tx_start.
  - Expect ack[2] and tx_start in the same cycle and tx_data=0xA5.
  - Expect sent[2] one cycle after tx_done, and cur_src=2 throughout.
- Rotation: all four req held, each byte done after 5 cycles.
  - Expect grant order 0, 1, 2, 3, 0.
  - Expect exactly one ack per transfer and at least one IDLE cycle between sent and the next tx_start.
- Busy gating: tx_busy=1 with req[1]=1 for 20 cycles, then tx_busy=0.
  - Expect no ack or tx_start while busy, and a grant one cycle after busy falls.
- Watchdog: TIMEOUT=16, no tx_done.
  - Expect err exactly 16 cycles after tx_start, no sent, and last updated so the next grant goes to a different pending source.
- Corner cases:
  - tx_done coincident with the final timeout cycle: expect sent and no err.
  - tx_done pulsed in IDLE: expect no effect.
- Reset: rst_n low for 1 cycle mid-WAIT.
  - Expect all outputs at 0 on the next cycle.
  - Expect source 0 to win the next arbitration when all request.
